// File: rtl/dmem_arb_pkg.sv
// Shared types and default parameters for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    IO   = 2'd2
  } owner_t;

  localparam int DEF_ADDR_W     = 14;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/dmem_arb_starve.sv
// Starvation guard: counts consecutive denied IO cycles and forces an IO
// grant once the count reaches STARVE_MAX.
module dmem_arb_starve
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic io_req_i,
  input  logic io_gnt_i,
  output logic force_io_o
);

  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!io_req_i || io_gnt_i) begin
      starve_cnt_d = 4'd0;
    end else begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign force_io_o = (starve_cnt_q == 4'(STARVE_MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/IO arbiter in front of the single-port data memory, CPU first.
// Define DMEM_ARB_STARVE_EN to bound IO waiting with the starvation guard.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [31:0]       io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] io_rdata,
  output logic              io_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              force_io;
  logic              gnt_any;
  logic              gnt_we;
  logic [31:0]       gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;
  logic              gnt_oor;
  owner_t            rd_owner_q, rd_owner_d;
  logic              rd_oor_q, rd_oor_d;

`ifdef DMEM_ARB_STARVE_EN
  dmem_arb_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .io_req_i  (io_req),
    .io_gnt_i  (io_gnt),
    .force_io_o(force_io)
  );
`else
  assign force_io = 1'b0;
`endif

  // Grants are held low while reset is asserted so nothing reaches memory.
  assign cpu_gnt = ~rst & cpu_req & ~(force_io & io_req);
  assign io_gnt  = ~rst & io_req & (~cpu_req | force_io);
  assign gnt_any = cpu_gnt | io_gnt;

  assign gnt_we    = io_gnt ? io_we    : cpu_we;
  assign gnt_addr  = io_gnt ? io_addr  : cpu_addr;
  assign gnt_wdata = io_gnt ? io_wdata : cpu_wdata;
  assign gnt_oor   = |gnt_addr[31:ADDR_W];

  // Out-of-range accesses are granted but never touch the memory.
  assign mem_en    = gnt_any & ~gnt_oor;
  assign mem_we    = mem_en & gnt_we;
  assign mem_addr  = gnt_addr[ADDR_W-1:0];
  assign mem_wdata = gnt_wdata;

  always_comb begin
    rd_owner_d = NONE;
    rd_oor_d   = 1'b0;
    if (gnt_any && !gnt_we) begin
      rd_owner_d = io_gnt ? IO : CPU;
      rd_oor_d   = gnt_oor;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_owner_q <= NONE;
      rd_oor_q   <= 1'b0;
    end else begin
      rd_owner_q <= rd_owner_d;
      rd_oor_q   <= rd_oor_d;
    end
  end

  assign cpu_rvalid = (rd_owner_q == CPU);
  assign io_rvalid  = (rd_owner_q == IO);
  assign cpu_err    = cpu_rvalid & rd_oor_q;
  assign io_err     = io_rvalid & rd_oor_q;
  assign cpu_rdata  = (cpu_rvalid && !rd_oor_q) ? mem_rdata : '0;
  assign io_rdata   = (io_rvalid && !rd_oor_q) ? mem_rdata : '0;

endmodule
